audio_frontend_mc: RTL and testbench

AUDIO_FRONTEND_MC -- requirements
Module: audio_frontend_mc

---
 rtl/audio_frontend_mc.sv | 177 +++++++++++++++++
 tb/tb_audio_frontend_mc.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frontend_mc.sv
// audio_frontend_mc: multi-channel microphone front end.
//   Per channel: DC-offset removal (saturating subtract of a calibrated or
//   bypassed offset) followed by a boxcar decimator of 2^DECIM_LOG2 samples.
//   A shared calibration FSM averages 2^CAL_LOG2 raw samples per channel
//   and stores the floor of each average as that channel's offset.
// Ports:
//   audio_clk, rst_in        clock, asynchronous active-high reset
//   sample_valid_in[k]       per-channel sample strobe
//   sample_in                packed signed samples, channel k at [k*WIDTH +: WIDTH]
//   cal_trigger_in           pulse that starts calibration
//   bypass_dc_in             level, forces the applied offset to zero
//   cal_busy_out             high while calibrating
//   cal_done_out             high once calibrated offsets are held
//   decim_valid_out[k]       per-channel single-cycle output strobe
//   decim_out                packed signed decimated samples, held between strobes
module audio_frontend_mc #(
  parameter int NUM_CH     = 2,
  parameter int WIDTH      = 16,
  parameter int CAL_LOG2   = 10,
  parameter int DECIM_LOG2 = 1
) (
  input  logic                    audio_clk,
  input  logic                    rst_in,
  input  logic [NUM_CH-1:0]       sample_valid_in,
  input  logic [NUM_CH*WIDTH-1:0] sample_in,
  input  logic                    cal_trigger_in,
  input  logic                    bypass_dc_in,
  output logic                    cal_busy_out,
  output logic                    cal_done_out,
  output logic [NUM_CH-1:0]       decim_valid_out,
  output logic [NUM_CH*WIDTH-1:0] decim_out
);

  localparam int ACC_W = WIDTH + CAL_LOG2;
  localparam int CNT_W = CAL_LOG2 + 1;
  localparam int SUM_W = WIDTH + DECIM_LOG2;
  localparam int PH_W  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;

  localparam logic [CNT_W-1:0] CAL_FULL = CNT_W'(2 ** CAL_LOG2);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 ** DECIM_LOG2 - 1);
  localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_UNCAL,
    ST_CAL,
    ST_DONE
  } cal_state_e;

  cal_state_e state_q, state_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic signed [ACC_W-1:0] acc_q   [NUM_CH];
  logic signed [ACC_W-1:0] acc_d   [NUM_CH];
  logic        [CNT_W-1:0] cnt_q   [NUM_CH];
  logic        [CNT_W-1:0] cnt_d   [NUM_CH];
  logic signed [WIDTH-1:0] off_q   [NUM_CH];
  logic signed [WIDTH-1:0] off_d   [NUM_CH];
  logic        [PH_W-1:0]  phase_q [NUM_CH];
  logic        [PH_W-1:0]  phase_d [NUM_CH];
  logic signed [SUM_W-1:0] sum_q   [NUM_CH];
  logic signed [SUM_W-1:0] sum_d   [NUM_CH];
  logic signed [WIDTH-1:0] dout_q  [NUM_CH];
  logic signed [WIDTH-1:0] dout_d  [NUM_CH];
  logic [NUM_CH-1:0]       dval_q, dval_d;

  logic signed [WIDTH-1:0] raw     [NUM_CH];
  logic signed [WIDTH-1:0] app_off [NUM_CH];
  logic signed [WIDTH:0]   diff    [NUM_CH];
  logic signed [WIDTH-1:0] corr    [NUM_CH];
  logic signed [SUM_W-1:0] total   [NUM_CH];
  logic signed [SUM_W-1:0] shifted [NUM_CH];
  logic                    all_full;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign raw[g]     = sample_in[g*WIDTH +: WIDTH];
    assign app_off[g] = bypass_dc_in ? '0 : off_q[g];
    assign diff[g]    = {raw[g][WIDTH-1], raw[g]} - {app_off[g][WIDTH-1], app_off[g]};
    // Overflow of the WIDTH+1 difference shows as disagreeing top two bits.
    assign corr[g]    = (diff[g][WIDTH] != diff[g][WIDTH-1]) ?
                        (diff[g][WIDTH] ? SAT_MIN : SAT_MAX) : diff[g][WIDTH-1:0];
    assign total[g]   = sum_q[g] + SUM_W'(corr[g]);
    assign shifted[g] = total[g] >>> DECIM_LOG2;
    assign decim_out[g*WIDTH +: WIDTH] = dout_q[g];
  end

  // Calibration FSM and offset storage
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    off_d    = off_q;
    all_full = 1'b1;
    if (state_q == ST_CAL) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (sample_valid_in[k] && (cnt_q[k] != CAL_FULL)) begin
          acc_d[k] = acc_q[k] + ACC_W'(raw[k]);
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (cnt_d[k] != CAL_FULL) all_full = 1'b0;
      end
      // Completion is judged on next-state counts so the offsets load on the
      // same edge that takes the final sample.
      if (all_full) begin
        state_d = ST_DONE;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          off_d[k] = WIDTH'(acc_d[k] >>> CAL_LOG2);
        end
      end
    end else if (cal_trigger_in) begin
      state_d = ST_CAL;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        acc_d[k] = '0;
        cnt_d[k] = '0;
      end
    end
    busy_d = (state_d == ST_CAL);
    done_d = (state_d == ST_DONE);
  end

  // Decimators
  always_comb begin
    phase_d = phase_q;
    sum_d   = sum_q;
    dout_d  = dout_q;
    dval_d  = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (sample_valid_in[k]) begin
        if (phase_q[k] == PH_LAST) begin
          dout_d[k]  = WIDTH'(shifted[k]);
          sum_d[k]   = '0;
          phase_d[k] = '0;
          dval_d[k]  = 1'b1;
        end else begin
          sum_d[k]   = total[k];
          phase_d[k] = phase_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_UNCAL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dval_q  <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        acc_q[k]   <= '0;
        cnt_q[k]   <= '0;
        off_q[k]   <= '0;
        phase_q[k] <= '0;
        sum_q[k]   <= '0;
        dout_q[k]  <= '0;
      end
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dval_q  <= dval_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      phase_q <= phase_d;
      sum_q   <= sum_d;
      dout_q  <= dout_d;
    end
  end

  assign cal_busy_out    = busy_q;
  assign cal_done_out    = done_q;
  assign decim_valid_out = dval_q;

endmodule

// File: tb/tb_audio_frontend_mc.sv
// Scoreboard bench for audio_frontend_mc (2 channels, 16-bit, 4-sample
// calibration, decimate by 2). Stimulus computes expected decimated values
// from a list-based reference model; a negedge monitor pops and compares.
module tb_audio_frontend_mc;
  localparam int NC = 2;
  localparam int W  = 16;
  localparam int CAL_N = 4;
  localparam int DEC_N = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC-1:0] vin = '0;
  logic [NC*W-1:0] sin = '0;
  logic          trig = 1'b0;
  logic          byp = 1'b0;
  logic          busy, done;
  logic [NC-1:0] dv;
  logic [NC*W-1:0] dout;

  audio_frontend_mc #(.NUM_CH(NC), .WIDTH(W), .CAL_LOG2(2), .DECIM_LOG2(1)) dut (
    .audio_clk(clk), .rst_in(rst), .sample_valid_in(vin), .sample_in(sin),
    .cal_trigger_in(trig), .bypass_dc_in(byp), .cal_busy_out(busy),
    .cal_done_out(done), .decim_valid_out(dv), .decim_out(dout));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: 0 = uncalibrated, 1 = calibrating, 2 = calibrated
  int m_state = 0;
  int m_off[NC];
  int m_cal[NC][$];
  int m_dec[NC][$];
  int exp_q[NC][$];

  function automatic int floor_div(int s, int n);
    if (s >= 0) return s / n;
    return -((-s + n - 1) / n);
  endfunction

  function automatic int sat(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_state = 0;
    for (int k = 0; k < NC; k++) begin
      m_off[k] = 0;
      m_cal[k].delete();
      m_dec[k].delete();
      exp_q[k].delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    #1;
    check("rst_decim_out", dout, 0);
    check("rst_decim_valid", dv, 0);
    check("rst_cal_busy", busy, 0);
    check("rst_cal_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock of stimulus; the model is advanced with the pre-edge state.
  task automatic step(logic [NC-1:0] v, int s0, int s1, logic t);
    int smp[NC];
    int s;
    bit full;
    smp[0] = s0;
    smp[1] = s1;
    vin  = v;
    trig = t;
    for (int k = 0; k < NC; k++) sin[k*W +: W] = W'(smp[k]);
    for (int k = 0; k < NC; k++) begin
      if (v[k]) begin
        m_dec[k].push_back(sat(smp[k] - (byp ? 0 : m_off[k])));
        if (m_dec[k].size() == DEC_N) begin
          s = 0;
          foreach (m_dec[k][i]) s += m_dec[k][i];
          exp_q[k].push_back(floor_div(s, DEC_N));
          m_dec[k].delete();
        end
      end
    end
    if (m_state == 1) begin
      full = 1'b1;
      for (int k = 0; k < NC; k++) begin
        if (v[k] && m_cal[k].size() < CAL_N) m_cal[k].push_back(smp[k]);
        if (m_cal[k].size() < CAL_N) full = 1'b0;
      end
      if (full) begin
        m_state = 2;
        for (int k = 0; k < NC; k++) begin
          s = 0;
          foreach (m_cal[k][i]) s += m_cal[k][i];
          m_off[k] = floor_div(s, CAL_N);
        end
      end
    end else if (t) begin
      m_state = 1;
      for (int k = 0; k < NC; k++) m_cal[k].delete();
    end
    @(posedge clk); #1;
    check("cal_busy", busy, (m_state == 1) ? 1 : 0);
    check("cal_done", done, (m_state == 2) ? 1 : 0);
    vin  = '0;
    trig = 1'b0;
  endtask

  // Monitor: every output strobe must match the oldest expected value.
  initial begin
    int got;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < NC; k++) begin
          if (dv[k]) begin
            got = $signed(dout[k*W +: W]);
            if (exp_q[k].size() == 0) begin
              check($sformatf("unexpected_strobe_ch%0d", k), 1, 0);
            end else begin
              check($sformatf("decim_ch%0d", k), got, exp_q[k].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    logic [NC-1:0] rv;
    int rs[NC];
    do_reset();

    // Reset mid-stream, then a fresh average
    step(2'b01, 555, 0, 1'b0);
    step(2'b11, 300, -20, 1'b0);
    step(2'b01, 100, 0, 1'b0);
    do_reset();
    step(2'b01, 100, 0, 1'b0);
    step(2'b01, 200, 0, 1'b0);
    step(2'b00, 0, 0, 1'b0);

    // Staggered calibration: offsets 40 and -8
    step(2'b00, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(2'b01, 40, 0, 1'b0);
      step(2'b10, 0, -8, 1'b0);
    end
    step(2'b01, 50, 0, 1'b0);
    step(2'b01, 50, 0, 1'b0);
    step(2'b10, 0, -8, 1'b0);
    step(2'b10, 0, -8, 1'b0);

    // Bypass keeps stored offsets
    byp = 1'b1;
    step(2'b01, 50, 0, 1'b0);
    step(2'b01, 50, 0, 1'b0);
    byp = 1'b0;
    step(2'b01, 50, 0, 1'b0);
    step(2'b01, 50, 0, 1'b0);

    // Saturation at both rails
    step(2'b00, 0, 0, 1'b1);
    repeat (4) step(2'b11, 1000, 0, 1'b0);
    step(2'b01, -32768, 0, 1'b0);
    step(2'b01, -32768, 0, 1'b0);
    step(2'b00, 0, 0, 1'b1);
    repeat (4) step(2'b11, -1000, 0, 1'b0);
    step(2'b01, 32767, 0, 1'b0);
    step(2'b01, 32767, 0, 1'b0);

    // Retrigger during calibration is ignored; reset abandons it
    step(2'b00, 0, 0, 1'b1);
    step(2'b11, 500, 500, 1'b0);
    step(2'b11, 500, 500, 1'b0);
    step(2'b00, 0, 0, 1'b1);
    step(2'b11, 700, 700, 1'b0);
    step(2'b01, 700, 0, 1'b0);
    do_reset();

    // Simultaneous channels, floor of negative average
    step(2'b11, 3, -3, 1'b0);
    step(2'b11, 4, -4, 1'b0);
    step(2'b01, 7, 0, 1'b0);
    step(2'b01, 9, 0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rv = 2'($urandom_range(0, 3));
      byp = ($urandom_range(0, 7) == 0);
      for (int j = 0; j < NC; j++) begin
        if ($urandom_range(0, 4) == 0) rs[j] = $signed(16'($urandom));
        else rs[j] = int'($urandom_range(0, 1200)) - 600;
      end
      step(rv, rs[0], rs[1], $urandom_range(0, 39) == 0);
      if (i == 200) do_reset();
    end
    byp = 1'b0;
    repeat (3) step(2'b00, 0, 0, 1'b0);
    for (int k = 0; k < NC; k++) check($sformatf("drain_ch%0d", k), exp_q[k].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
